hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_pkg.sv | 40 ++++
 rtl/hazard_ctrl_sat_counter.sv | 27 ++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, control bundle
// layout and the load-use detection helper.
package hazard_ctrl_pkg;

   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {
      HZ_INIT = 2'd0,
      HZ_RUN  = 2'd1,
      HZ_HALT = 2'd2
   } hz_state_t;

   // Control bundle driven onto the PC / IF_ID / ID_EX registers
   typedef struct packed {
      logic pc_wren;
      logic if_id_wren;
      logic if_id_flush;
      logic id_ex_flush;
   } hz_ctrl_t;

   localparam hz_ctrl_t CTRL_FLUSH_ALL = '{pc_wren: 1'b1, if_id_wren: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1};
   localparam hz_ctrl_t CTRL_NORMAL    = '{pc_wren: 1'b1, if_id_wren: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0};
   localparam hz_ctrl_t CTRL_STALL     = '{pc_wren: 1'b0, if_id_wren: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b1};
   localparam hz_ctrl_t CTRL_HALT_IN   = '{pc_wren: 1'b1, if_id_wren: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b1};
   localparam hz_ctrl_t CTRL_JUMP      = '{pc_wren: 1'b1, if_id_wren: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b0};

   // A load in EX whose destination (non-zero) is read by the ID instruction
   function automatic logic load_use_hit(
      input logic       ex_load,
      input logic [4:0] ex_rt,
      input logic       uses_rs,
      input logic [4:0] id_rs,
      input logic       uses_rt,
      input logic [4:0] id_rt
   );
      return ex_load && (ex_rt != 5'd0) &&
             ((uses_rs && (id_rs == ex_rt)) || (uses_rt && (id_rt == ex_rt)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// 32-bit saturating event counter with synchronous clear (clear beats inc).
module sat_counter32
   import hazard_ctrl_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   // Count events, holding at all-ones instead of wrapping
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes,
// post-reset bubbling, halt parking, and stall/flush performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned RESET_FLUSH_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  ID_RS,
   input  logic [4:0]  ID_RT,
   input  logic        ID_UsesRS,
   input  logic        ID_UsesRT,
   input  logic        ID_Jump,
   input  logic        ID_Halt,
   input  logic        EX_MEM_RDEN,
   input  logic [4:0]  EX_RT,
   input  logic        EX_BranchTaken,
   input  logic        resume,
   input  logic        count_clear,
   output logic        PC_WREN,
   output logic        IF_ID_WREN,
   output logic        IF_ID_flush,
   output logic        ID_EX_flush,
   output logic        halted,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
);

   hz_state_t  state;
   logic [3:0] init_cnt;
   hz_ctrl_t   ctrl;
   logic       load_use;
   logic       stall_inc;
   logic       flush_inc;
   logic       halt_req;

   assign load_use = load_use_hit(EX_MEM_RDEN, EX_RT, ID_UsesRS, ID_RS, ID_UsesRT, ID_RT);

   // Control outputs are combinational so a load-use bubble lands on this edge
   always_comb begin
      ctrl      = CTRL_NORMAL;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      halt_req  = 1'b0;
      unique case (state)
         HZ_INIT: ctrl = CTRL_FLUSH_ALL;
         HZ_RUN: begin
            if (EX_BranchTaken) begin
               ctrl      = CTRL_FLUSH_ALL;
               flush_inc = 1'b1;
            end else if (load_use) begin
               ctrl      = CTRL_STALL;
               stall_inc = 1'b1;
            end else if (ID_Halt) begin
               ctrl      = CTRL_HALT_IN;
               halt_req  = 1'b1;
            end else if (ID_Jump) begin
               ctrl      = CTRL_JUMP;
               flush_inc = 1'b1;
            end
         end
         HZ_HALT: ctrl = CTRL_STALL;
         default: ctrl = CTRL_FLUSH_ALL;
      endcase
   end

   // State and post-reset bubble counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= HZ_INIT;
         init_cnt <= 4'(RESET_FLUSH_CYCLES);
      end else begin
         unique case (state)
            HZ_INIT: begin
               init_cnt <= init_cnt - 4'd1;
               if (init_cnt == 4'd1) state <= HZ_RUN;
            end
            HZ_RUN:  if (halt_req) state <= HZ_HALT;
            HZ_HALT: if (resume)   state <= HZ_RUN;
            default: state <= HZ_INIT;
         endcase
      end
   end

   assign PC_WREN     = ctrl.pc_wren;
   assign IF_ID_WREN  = ctrl.if_id_wren;
   assign IF_ID_flush = ctrl.if_id_flush;
   assign ID_EX_flush = ctrl.id_ex_flush;
   assign halted      = (state == HZ_HALT);

   sat_counter32 u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .clear (count_clear),
      .inc   (stall_inc),
      .count (stall_count)
   );

   sat_counter32 u_flush_cnt (
      .clock (clock),
      .reset (reset),
      .clear (count_clear),
      .inc   (flush_inc),
      .count (flush_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver pushes hand-computed expectations
// into a scoreboard queue, a negedge monitor pops and compares.
module tb_hazard_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  ID_RS, ID_RT, EX_RT;
   logic        ID_UsesRS, ID_UsesRT, ID_Jump, ID_Halt;
   logic        EX_MEM_RDEN, EX_BranchTaken, resume, count_clear;
   logic        PC_WREN, IF_ID_WREN, IF_ID_flush, ID_EX_flush, halted;
   logic [31:0] stall_count, flush_count;

   hazard_ctrl #(.RESET_FLUSH_CYCLES(2)) dut (
      .clock          (clock),
      .reset          (reset),
      .ID_RS          (ID_RS),
      .ID_RT          (ID_RT),
      .ID_UsesRS      (ID_UsesRS),
      .ID_UsesRT      (ID_UsesRT),
      .ID_Jump        (ID_Jump),
      .ID_Halt        (ID_Halt),
      .EX_MEM_RDEN    (EX_MEM_RDEN),
      .EX_RT          (EX_RT),
      .EX_BranchTaken (EX_BranchTaken),
      .resume         (resume),
      .count_clear    (count_clear),
      .PC_WREN        (PC_WREN),
      .IF_ID_WREN     (IF_ID_WREN),
      .IF_ID_flush    (IF_ID_flush),
      .ID_EX_flush    (ID_EX_flush),
      .halted         (halted),
      .stall_count    (stall_count),
      .flush_count    (flush_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [3:0]  ctl;   // {PC_WREN, IF_ID_WREN, IF_ID_flush, ID_EX_flush}
      logic        hlt;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t        sbq[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_sc = '0;
   logic [31:0] exp_fc = '0;

   // Monitor: compare DUT outputs mid-cycle against the oldest expectation
   always @(negedge clock) begin
      if (sbq.size() > 0) begin
         exp_t       e;
         logic [3:0] act;
         e   = sbq.pop_front();
         act = {PC_WREN, IF_ID_WREN, IF_ID_flush, ID_EX_flush};
         tests++;
         if (act !== e.ctl || halted !== e.hlt || stall_count !== e.sc || flush_count !== e.fc) begin
            fails++;
            $display("FAIL %s: got ctl=%b halted=%b stall=%0d flush=%0d, want ctl=%b halted=%b stall=%0d flush=%0d",
                     e.name, act, halted, stall_count, flush_count, e.ctl, e.hlt, e.sc, e.fc);
         end
      end
   end

   task automatic idle();
      ID_RS = '0; ID_RT = '0; EX_RT = '0;
      ID_UsesRS = 1'b0; ID_UsesRT = 1'b0; ID_Jump = 1'b0; ID_Halt = 1'b0;
      EX_MEM_RDEN = 1'b0; EX_BranchTaken = 1'b0; resume = 1'b0; count_clear = 1'b0;
   endtask

   // Queue this cycle's expectation, then advance to just after the next edge
   task automatic cyc(input string nm, input logic [3:0] ctl, input logic hlt);
      exp_t e;
      e.name = nm; e.ctl = ctl; e.hlt = hlt; e.sc = exp_sc; e.fc = exp_fc;
      sbq.push_back(e);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle();
      repeat (2) @(posedge clock);
      #1;
      cyc("reset_hold", 4'b1111, 1'b0);
      reset = 1'b0;

      // INIT lasts exactly two cycles; branch/resume must not disturb it
      cyc("init_1", 4'b1111, 1'b0);
      EX_BranchTaken = 1'b1; resume = 1'b1;
      cyc("init_2_ignores_inputs", 4'b1111, 1'b0);
      idle();
      resume = 1'b1;
      cyc("run_idle_resume_ignored", 4'b1100, 1'b0);
      idle();

      // Load-use on RT
      EX_MEM_RDEN = 1'b1; EX_RT = 5'd5; ID_UsesRT = 1'b1; ID_RT = 5'd5;
      cyc("load_use_rt", 4'b0001, 1'b0);
      exp_sc = 32'd1;
      idle();
      cyc("after_stall", 4'b1100, 1'b0);

      // Load-use on RS
      EX_MEM_RDEN = 1'b1; EX_RT = 5'd7; ID_UsesRS = 1'b1; ID_RS = 5'd7;
      cyc("load_use_rs", 4'b0001, 1'b0);
      exp_sc = 32'd2;

      // Register 0 never stalls; unused operand never stalls
      idle();
      EX_MEM_RDEN = 1'b1; EX_RT = 5'd0; ID_UsesRT = 1'b1; ID_RT = 5'd0;
      cyc("no_stall_r0", 4'b1100, 1'b0);
      idle();
      EX_MEM_RDEN = 1'b1; EX_RT = 5'd9; ID_UsesRT = 1'b0; ID_RT = 5'd9;
      cyc("no_stall_unused", 4'b1100, 1'b0);

      // Branch beats a same-cycle load-use
      idle();
      EX_BranchTaken = 1'b1; EX_MEM_RDEN = 1'b1; EX_RT = 5'd5; ID_UsesRT = 1'b1; ID_RT = 5'd5;
      cyc("branch_over_load_use", 4'b1111, 1'b0);
      exp_fc = 32'd1;

      // Jump
      idle();
      ID_Jump = 1'b1;
      cyc("jump", 4'b1110, 1'b0);
      exp_fc = 32'd2;

      // Branch squashes a wrong-path halt
      idle();
      EX_BranchTaken = 1'b1; ID_Halt = 1'b1;
      cyc("branch_over_halt", 4'b1111, 1'b0);
      exp_fc = 32'd3;
      idle();
      cyc("no_halt_entry", 4'b1100, 1'b0);

      // Halt beats jump; then park for ten cycles with noise on the inputs
      ID_Halt = 1'b1; ID_Jump = 1'b1;
      cyc("halt_entry", 4'b1101, 1'b0);
      for (int i = 0; i < 10; i++) begin
         idle();
         EX_BranchTaken = i[0]; ID_Jump = i[1]; ID_Halt = i[2];
         EX_MEM_RDEN = 1'b1; EX_RT = 5'd3; ID_UsesRS = 1'b1; ID_RS = 5'd3;
         cyc("halt_hold", 4'b0001, 1'b1);
      end
      idle();
      resume = 1'b1;
      cyc("resume_cycle", 4'b0001, 1'b1);
      idle();
      cyc("after_resume", 4'b1100, 1'b0);

      // Saturation: preload flush_count to all-ones, a jump must not wrap it
      force dut.u_flush_cnt.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_flush_cnt.count_q;
      exp_fc = 32'hFFFF_FFFF;
      ID_Jump = 1'b1;
      cyc("jump_at_max", 4'b1110, 1'b0);
      idle();
      cyc("saturated", 4'b1100, 1'b0);

      // Clear wins over a same-cycle increment
      ID_Jump = 1'b1; count_clear = 1'b1;
      cyc("clear_with_jump", 4'b1110, 1'b0);
      exp_fc = '0; exp_sc = '0;
      idle();
      cyc("cleared", 4'b1100, 1'b0);

      // Reset while halted returns straight to INIT with counters zeroed
      EX_MEM_RDEN = 1'b1; EX_RT = 5'd4; ID_UsesRT = 1'b1; ID_RT = 5'd4;
      cyc("load_use_pre_halt", 4'b0001, 1'b0);
      exp_sc = 32'd1;
      idle();
      ID_Halt = 1'b1;
      cyc("halt_entry_2", 4'b1101, 1'b0);
      idle();
      cyc("halted_2", 4'b0001, 1'b1);
      reset = 1'b1;
      exp_sc = '0;
      cyc("reset_mid_halt", 4'b1111, 1'b0);
      reset = 1'b0;
      cyc("reinit_1", 4'b1111, 1'b0);
      cyc("reinit_2", 4'b1111, 1'b0);
      cyc("rerun", 4'b1100, 1'b0);

      for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clock);
      if (sbq.size() > 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations, want 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
